// File: rtl/mem_bank_ctrl_pkg.sv
// mem_bank_ctrl_pkg
// Derives the address-split widths and the capacity of the banked memory tile
// from the controller parameters. Also holds the round-robin pointer update
// shared by every bank arbiter.
package mem_bank_ctrl_pkg;

    // Index width that never collapses to zero, for selects over one item.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned off_w(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

    function automatic int unsigned bank_w(input int unsigned num_banks);
        return $clog2(num_banks);
    endfunction

    function automatic int unsigned row_w(input int unsigned num_words);
        return $clog2(num_words);
    endfunction

    function automatic int unsigned mac_w(input int unsigned num_macros);
        return $clog2(num_macros);
    endfunction

    // log2 of the capacity in bytes; any address bit at or above this is out of range.
    function automatic int unsigned cap_bits(input int unsigned num_banks,
                                             input int unsigned num_macros,
                                             input int unsigned num_words,
                                             input int unsigned data_width);
        return off_w(data_width) + bank_w(num_banks) + row_w(num_words) + mac_w(num_macros);
    endfunction

    function automatic longint unsigned capacity_bytes(input int unsigned num_banks,
                                                       input int unsigned num_macros,
                                                       input int unsigned num_words,
                                                       input int unsigned data_width);
        return longint'(1) << cap_bits(num_banks, num_macros, num_words, data_width);
    endfunction

    // Round-robin pointer moves to one past the granted port.
    function automatic int unsigned rr_next(input int unsigned granted, input int unsigned num_ports);
        return (granted + 1 >= num_ports) ? 0 : granted + 1;
    endfunction

endpackage

// File: rtl/mem_bank_arb.sv
// mem_bank_arb
// One bank's round-robin arbiter plus the mux that steers the winning port's
// access onto exactly one of the bank's stacked macros.
// Ports:
//   clk_i, rst_i  clock, async active-high reset
//   req_i         per-port in-range requests already decoded to this bank
//   gnt_o         one-hot grant (combinational)
//   we_i/row_i/mac_i/be_i/wdata_i  per-port access fields, flattened
//   mac_req_o     per-macro request strobe
//   we_o/row_o/be_o/wdata_o        winning access, shared by all macros
module mem_bank_arb
    import mem_bank_ctrl_pkg::*;
#(
    parameter int unsigned NumPorts  = 2,
    parameter int unsigned NumMacros = 2,
    parameter int unsigned RowW      = 9,
    parameter int unsigned MacIdxW   = 1,
    parameter int unsigned DataWidth = 64
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NumPorts-1:0]               req_i,
    output logic [NumPorts-1:0]               gnt_o,
    input  logic [NumPorts-1:0]               we_i,
    input  logic [NumPorts*RowW-1:0]          row_i,
    input  logic [NumPorts*MacIdxW-1:0]       mac_i,
    input  logic [NumPorts*DataWidth/8-1:0]   be_i,
    input  logic [NumPorts*DataWidth-1:0]     wdata_i,
    output logic [NumMacros-1:0]              mac_req_o,
    output logic                              we_o,
    output logic [RowW-1:0]                   row_o,
    output logic [DataWidth/8-1:0]            be_o,
    output logic [DataWidth-1:0]              wdata_o
);

    localparam int unsigned PortW = clog2_min1(NumPorts);
    localparam int unsigned BeW   = DataWidth / 8;

    logic [PortW-1:0] ptr_q, ptr_d, sel;
    logic             any;
    logic [PortW:0]   idx_ext;

    // Scan ports starting at the pointer; first requester wins.
    always_comb begin
        gnt_o   = '0;
        sel     = '0;
        any     = 1'b0;
        idx_ext = '0;
        for (int k = 0; k < NumPorts; k++) begin
            idx_ext = {1'b0, ptr_q} + (PortW+1)'(k);
            if (idx_ext >= (PortW+1)'(NumPorts)) begin
                idx_ext = idx_ext - (PortW+1)'(NumPorts);
            end
            if (!any && req_i[idx_ext[PortW-1:0]]) begin
                any = 1'b1;
                sel = idx_ext[PortW-1:0];
            end
        end
        if (any) begin
            gnt_o[sel] = 1'b1;
        end
        ptr_d = PortW'(rr_next(int'(sel), NumPorts));
    end

    always_comb begin
        mac_req_o = '0;
        we_o      = 1'b0;
        row_o     = '0;
        be_o      = '0;
        wdata_o   = '0;
        if (any) begin
            mac_req_o[mac_i[sel*MacIdxW +: MacIdxW]] = 1'b1;
            we_o    = we_i[sel];
            row_o   = row_i[sel*RowW +: RowW];
            be_o    = be_i[sel*BeW +: BeW];
            wdata_o = wdata_i[sel*DataWidth +: DataWidth];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else if (any) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/tc_sram.sv
// tc_sram
// Single-port SRAM macro model with byte enables and a fixed read latency.
// Read-first: a read returns the word as stored before this cycle's edge.
// Contents are not reset.
// Ports:
//   clk_i    clock
//   req_i    access strobe
//   we_i     1 = write
//   addr_i   word address
//   be_i     byte enables (writes)
//   wdata_i  write data
//   rdata_o  read data, Latency cycles after a read request
module tc_sram
    import mem_bank_ctrl_pkg::*;
#(
    parameter int unsigned NumWords  = 512,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned Latency   = 1,
    parameter int unsigned AddrW     = clog2_min1(NumWords)
) (
    input  logic                   clk_i,
    input  logic                   req_i,
    input  logic                   we_i,
    input  logic [AddrW-1:0]       addr_i,
    input  logic [DataWidth/8-1:0] be_i,
    input  logic [DataWidth-1:0]   wdata_i,
    output logic [DataWidth-1:0]   rdata_o
);

    logic [DataWidth-1:0] mem_q [NumWords];
    logic [DataWidth-1:0] rd_q  [Latency];

    always_ff @(posedge clk_i) begin
        if (req_i) begin
            if (we_i) begin
                for (int i = 0; i < DataWidth / 8; i++) begin
                    if (be_i[i]) begin
                        mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
                    end
                end
            end else begin
                rd_q[0] <= mem_q[addr_i];
            end
        end
        for (int k = 1; k < Latency; k++) begin
            rd_q[k] <= rd_q[k-1];
        end
    end

    assign rdata_o = rd_q[Latency-1];

endmodule

// File: rtl/mem_bank_ctrl.sv
// mem_bank_ctrl
// Multi-port, word-interleaved, banked SRAM controller. Each bank arbitrates
// round-robin among the ports addressing it; out-of-range requests bypass
// arbitration and return an error. Every grant produces one response exactly
// SramLatency cycles later, for reads and writes alike.
// Ports:
//   clk_i, rst_i  clock, async active-high reset
//   req_i/gnt_o   per-port request / combinational grant
//   addr_i        per-port byte address
//   we_i, be_i, wdata_i  per-port write control and data
//   rvalid_o, rdata_o, err_o  per-port response (rdata 0 on write or error)
//   busy_o        any response in flight
module mem_bank_ctrl
    import mem_bank_ctrl_pkg::*;
#(
    parameter int unsigned NumPorts         = 2,
    parameter int unsigned NumBanks         = 4,
    parameter int unsigned NumMacrosPerBank = 2,
    parameter int unsigned SramNumWords     = 512,
    parameter int unsigned DataWidth        = 64,
    parameter int unsigned AddrWidth        = 32,
    parameter int unsigned SramLatency      = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NumPorts-1:0]               req_i,
    output logic [NumPorts-1:0]               gnt_o,
    input  logic [NumPorts*AddrWidth-1:0]     addr_i,
    input  logic [NumPorts-1:0]               we_i,
    input  logic [NumPorts*DataWidth/8-1:0]   be_i,
    input  logic [NumPorts*DataWidth-1:0]     wdata_i,
    output logic [NumPorts-1:0]               rvalid_o,
    output logic [NumPorts*DataWidth-1:0]     rdata_o,
    output logic [NumPorts-1:0]               err_o,
    output logic                              busy_o
);

    localparam int unsigned OffW     = off_w(DataWidth);
    localparam int unsigned BankW    = bank_w(NumBanks);
    localparam int unsigned RowW     = row_w(SramNumWords);
    localparam int unsigned MacW     = mac_w(NumMacrosPerBank);
    localparam int unsigned CapBits  = cap_bits(NumBanks, NumMacrosPerBank, SramNumWords, DataWidth);
    localparam int unsigned BankIdxW = clog2_min1(NumBanks);
    localparam int unsigned MacIdxW  = clog2_min1(NumMacrosPerBank);
    localparam int unsigned BeW      = DataWidth / 8;

    // Offset bits below the word never select anything.
    logic unused_addr;
    assign unused_addr = ^addr_i;

    logic [BankIdxW-1:0]         bank_p [NumPorts];
    logic [MacIdxW-1:0]          mac_p  [NumPorts];
    logic [NumPorts-1:0]         oor_p;
    logic [NumPorts*RowW-1:0]    row_flat;
    logic [NumPorts*MacIdxW-1:0] mac_flat;

    for (genvar p = 0; p < NumPorts; p++) begin : g_dec
        logic [AddrWidth-1:0] a;
        assign a = addr_i[p*AddrWidth +: AddrWidth];
        if (BankW > 0) begin : g_bank_sel
            assign bank_p[p] = a[OffW +: BankW];
        end else begin : g_bank_one
            assign bank_p[p] = '0;
        end
        if (MacW > 0) begin : g_mac_sel
            assign mac_p[p] = a[OffW+BankW+RowW +: MacW];
        end else begin : g_mac_one
            assign mac_p[p] = '0;
        end
        assign row_flat[p*RowW +: RowW]       = a[OffW+BankW +: RowW];
        assign mac_flat[p*MacIdxW +: MacIdxW] = mac_p[p];
        assign oor_p[p]                       = |(a >> CapBits);
    end

    logic [NumPorts-1:0] bank_req [NumBanks];
    logic [NumPorts-1:0] bank_gnt [NumBanks];

    always_comb begin
        for (int b = 0; b < NumBanks; b++) begin
            for (int p = 0; p < NumPorts; p++) begin
                bank_req[b][p] = req_i[p] && !oor_p[p] && (bank_p[p] == BankIdxW'(b));
            end
        end
    end

    // Out-of-range requests are accepted on the spot; nothing to arbitrate.
    always_comb begin
        gnt_o = req_i & oor_p;
        for (int b = 0; b < NumBanks; b++) begin
            gnt_o = gnt_o | bank_gnt[b];
        end
    end

    logic [DataWidth-1:0] sram_rdata [NumBanks][NumMacrosPerBank];

    for (genvar b = 0; b < NumBanks; b++) begin : g_bank
        logic [NumMacrosPerBank-1:0] mreq;
        logic                        mwe;
        logic [RowW-1:0]             mrow;
        logic [BeW-1:0]              mbe;
        logic [DataWidth-1:0]        mwdata;

        mem_bank_arb #(
            .NumPorts  (NumPorts),
            .NumMacros (NumMacrosPerBank),
            .RowW      (RowW),
            .MacIdxW   (MacIdxW),
            .DataWidth (DataWidth)
        ) i_arb (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .req_i     (bank_req[b]),
            .gnt_o     (bank_gnt[b]),
            .we_i      (we_i),
            .row_i     (row_flat),
            .mac_i     (mac_flat),
            .be_i      (be_i),
            .wdata_i   (wdata_i),
            .mac_req_o (mreq),
            .we_o      (mwe),
            .row_o     (mrow),
            .be_o      (mbe),
            .wdata_o   (mwdata)
        );

        for (genvar m = 0; m < NumMacrosPerBank; m++) begin : g_mac
            tc_sram #(
                .NumWords  (SramNumWords),
                .DataWidth (DataWidth),
                .Latency   (SramLatency),
                .AddrW     (RowW)
            ) i_sram (
                .clk_i   (clk_i),
                .req_i   (mreq[m]),
                .we_i    (mwe),
                .addr_i  (mrow),
                .be_i    (mbe),
                .wdata_i (mwdata),
                .rdata_o (sram_rdata[b][m])
            );
        end
    end

    // Response pipeline, aligned with the macro read latency so the last
    // stage's bank/macro selects the word the SRAM presents in that cycle.
    logic                v_q    [NumPorts][SramLatency];
    logic                e_q    [NumPorts][SramLatency];
    logic                w_q    [NumPorts][SramLatency];
    logic [BankIdxW-1:0] bank_q [NumPorts][SramLatency];
    logic [MacIdxW-1:0]  mac_q  [NumPorts][SramLatency];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int p = 0; p < NumPorts; p++) begin
                for (int k = 0; k < SramLatency; k++) begin
                    v_q[p][k]    <= 1'b0;
                    e_q[p][k]    <= 1'b0;
                    w_q[p][k]    <= 1'b0;
                    bank_q[p][k] <= '0;
                    mac_q[p][k]  <= '0;
                end
            end
        end else begin
            for (int p = 0; p < NumPorts; p++) begin
                v_q[p][0]    <= gnt_o[p];
                e_q[p][0]    <= oor_p[p];
                w_q[p][0]    <= we_i[p];
                bank_q[p][0] <= bank_p[p];
                mac_q[p][0]  <= mac_p[p];
                for (int k = 1; k < SramLatency; k++) begin
                    v_q[p][k]    <= v_q[p][k-1];
                    e_q[p][k]    <= e_q[p][k-1];
                    w_q[p][k]    <= w_q[p][k-1];
                    bank_q[p][k] <= bank_q[p][k-1];
                    mac_q[p][k]  <= mac_q[p][k-1];
                end
            end
        end
    end

    always_comb begin
        rvalid_o = '0;
        err_o    = '0;
        rdata_o  = '0;
        busy_o   = 1'b0;
        for (int p = 0; p < NumPorts; p++) begin
            rvalid_o[p] = v_q[p][SramLatency-1];
            err_o[p]    = v_q[p][SramLatency-1] && e_q[p][SramLatency-1];
            if (v_q[p][SramLatency-1] && !e_q[p][SramLatency-1] && !w_q[p][SramLatency-1]) begin
                rdata_o[p*DataWidth +: DataWidth] =
                    sram_rdata[bank_q[p][SramLatency-1]][mac_q[p][SramLatency-1]];
            end
            for (int k = 0; k < SramLatency; k++) begin
                busy_o = busy_o | v_q[p][k];
            end
        end
    end

endmodule

// File: tb/tb_mem_bank_ctrl.sv
// Scoreboarded bench for mem_bank_ctrl: one instance at SramLatency=1 for the
// functional vectors, one at SramLatency=2 for the reset-flush case.
module tb_mem_bank_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    int   cyc = 0;
    int   nvec = 0;
    int   nfail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]   a_req, a_we, a_gnt, a_rv, a_err, b_req, b_we, b_gnt, b_rv, b_err;
    logic [63:0]  a_addr, b_addr;
    logic [15:0]  a_be, b_be;
    logic [127:0] a_wd, b_wd, a_rd, b_rd;
    logic         a_busy, b_busy;

    mem_bank_ctrl #(.SramLatency(1)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(a_req), .gnt_o(a_gnt), .addr_i(a_addr),
        .we_i(a_we), .be_i(a_be), .wdata_i(a_wd), .rvalid_o(a_rv), .rdata_o(a_rd),
        .err_o(a_err), .busy_o(a_busy)
    );

    mem_bank_ctrl #(.SramLatency(2)) dut2 (
        .clk_i(clk), .rst_i(rst2), .req_i(b_req), .gnt_o(b_gnt), .addr_i(b_addr),
        .we_i(b_we), .be_i(b_be), .wdata_i(b_wd), .rvalid_o(b_rv), .rdata_o(b_rd),
        .err_o(b_err), .busy_o(b_busy)
    );

    typedef struct {
        int          due;
        logic        err;
        logic [63:0] data;
    } exp_t;

    // Index = dut*2 + port.
    exp_t sb [4][$];

    logic        mv    [4];
    logic        merr  [4];
    logic [63:0] mdata [4];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            mv[i]      = a_rv[i];
            merr[i]    = a_err[i];
            mdata[i]   = a_rd[i*64 +: 64];
            mv[i+2]    = b_rv[i];
            merr[i+2]  = b_err[i];
            mdata[i+2] = b_rd[i*64 +: 64];
        end
    end

    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            if (mv[i]) begin
                nvec++;
                if (sb[i].size() == 0) begin
                    nfail++;
                    $display("FAIL spurious_rvalid[%0d] cyc %0d: got rvalid=1 want none", i, cyc);
                end else begin
                    e = sb[i].pop_front();
                    if (e.due != cyc || merr[i] !== e.err || mdata[i] !== e.data) begin
                        nfail++;
                        $display("FAIL resp[%0d]: got cyc=%0d err=%b rdata=%h want cyc=%0d err=%b rdata=%h",
                                 i, cyc, merr[i], mdata[i], e.due, e.err, e.data);
                    end
                end
            end else if (sb[i].size() != 0 && sb[i][0].due <= cyc) begin
                e = sb[i].pop_front();
                nvec++;
                nfail++;
                $display("FAIL missing_rvalid[%0d]: got none at cyc %0d want err=%b rdata=%h", i, cyc, e.err, e.data);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        nvec++;
        if (got !== want) begin
            nfail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic push(input int i, input int lat, input logic err, input logic [63:0] data);
        exp_t e;
        e.due  = cyc + lat;
        e.err  = err;
        e.data = data;
        sb[i].push_back(e);
    endtask

    task automatic drv(input int d, input int p, input logic r, input logic w,
                       input logic [31:0] ad, input logic [7:0] be, input logic [63:0] wd);
        if (d == 0) begin
            a_req[p] = r; a_we[p] = w; a_addr[p*32 +: 32] = ad;
            a_be[p*8 +: 8] = be; a_wd[p*64 +: 64] = wd;
        end else begin
            b_req[p] = r; b_we[p] = w; b_addr[p*32 +: 32] = ad;
            b_be[p*8 +: 8] = be; b_wd[p*64 +: 64] = wd;
        end
    endtask

    // Start of a cycle: 1 time unit after the edge, all requests dropped.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) drv(d, p, 1'b0, 1'b0, 32'h0, 8'h00, 64'h0);
        end
    endtask

    task automatic settle();
        #3;
    endtask

    function automatic int pending();
        return sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size();
    endfunction

    localparam logic [63:0] D40  = 64'hDEADBEEF_CAFEF00D;
    localparam logic [63:0] D08  = 64'h1111_2222_3333_4444;
    localparam logic [63:0] D28  = 64'h5555_6666_7777_8888;
    localparam logic [63:0] DTOP = 64'h5A5A_A5A5_0F0F_F0F0;
    localparam logic [63:0] DX   = 64'hA5A5_0F0F_1234_5678;

    initial begin
        a_req = '0; a_we = '0; a_addr = '0; a_be = '0; a_wd = '0;
        b_req = '0; b_we = '0; b_addr = '0; b_be = '0; b_wd = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_a", {59'd0, a_gnt, a_rv, a_busy}, 64'd0);
        chk("reset_b", {59'd0, b_gnt, b_rv, b_busy}, 64'd0);
        rst = 1'b0;
        rst2 = 1'b0;

        for (int i = 0; i < 10; i++) begin
            tick(); settle();
            chk("idle", {54'd0, a_gnt, a_rv, a_err, a_busy, b_gnt, b_rv, b_busy}, 64'd0);
        end

        // Single-port write then read.
        tick(); drv(0, 0, 1, 1, 32'h40, 8'hFF, D40); settle();
        chk("wr40_gnt", a_gnt, 2'b01); push(0, 1, 0, 64'h0);
        tick(); drv(0, 0, 1, 0, 32'h40, 8'hFF, 64'h0); settle();
        chk("rd40_gnt", a_gnt, 2'b01); chk("busy_inflight", a_busy, 1'b1);
        push(0, 1, 0, D40);

        // Preload bank 1 rows 0 and 1, then contend for bank 1.
        tick(); drv(0, 0, 1, 1, 32'h08, 8'hFF, D08); settle();
        chk("wr08_gnt", a_gnt, 2'b01); push(0, 1, 0, 64'h0);
        tick(); drv(0, 1, 1, 1, 32'h28, 8'hFF, D28); settle();
        chk("wr28_gnt", a_gnt, 2'b10); push(1, 1, 0, 64'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            drv(0, 0, 1, 0, 32'h08, 8'hFF, 64'h0);
            drv(0, 1, 1, 0, 32'h28, 8'hFF, 64'h0);
            settle();
            if (i % 2 == 0) begin
                chk("conflict_gnt_p0", a_gnt, 2'b01); push(0, 1, 0, D08);
            end else begin
                chk("conflict_gnt_p1", a_gnt, 2'b10); push(1, 1, 0, D28);
            end
        end

        // Parallel banks plus byte-enable merging on bank 0.
        tick(); drv(0, 0, 1, 1, 32'h00, 8'hFF, 64'h0123_4567_89AB_CDEF);
        drv(0, 1, 1, 0, 32'h08, 8'hFF, 64'h0); settle();
        chk("parallel_gnt", a_gnt, 2'b11); push(0, 1, 0, 64'h0); push(1, 1, 0, D08);
        tick(); drv(0, 0, 1, 1, 32'h00, 8'hF0, 64'hFFFF_FFFF_FFFF_FFFF);
        drv(0, 1, 1, 0, 32'h28, 8'hFF, 64'h0); settle();
        chk("parallel_be_gnt", a_gnt, 2'b11); push(0, 1, 0, 64'h0); push(1, 1, 0, D28);
        tick(); drv(0, 0, 1, 1, 32'h00, 8'h00, 64'h0); settle();
        chk("be0_gnt", a_gnt, 2'b01); push(0, 1, 0, 64'h0);
        tick(); drv(0, 0, 1, 0, 32'h00, 8'hFF, 64'h0);
        drv(0, 1, 1, 1, 32'h7FF8, 8'hFF, DTOP); settle();
        chk("rd00_wrtop_gnt", a_gnt, 2'b11);
        push(0, 1, 0, 64'hFFFF_FFFF_89AB_CDEF); push(1, 1, 0, 64'h0);

        // Capacity boundary and out-of-range handling.
        tick(); drv(0, 0, 1, 0, 32'h7FF8, 8'hFF, 64'h0);
        drv(0, 1, 1, 0, 32'h8000, 8'hFF, 64'h0); settle();
        chk("top_oor_gnt", a_gnt, 2'b11); push(0, 1, 0, DTOP); push(1, 1, 1, 64'h0);
        tick(); drv(0, 0, 1, 0, 32'h08, 8'hFF, 64'h0);
        drv(0, 1, 1, 0, 32'h0001_0008, 8'hFF, 64'h0); settle();
        chk("oor_alias_gnt", a_gnt, 2'b11); push(0, 1, 0, D08); push(1, 1, 1, 64'h0);
        tick(); drv(0, 1, 1, 0, 32'h0001_0000, 8'hFF, 64'h0); settle();
        chk("oor_rd_gnt", a_gnt, 2'b10); push(1, 1, 1, 64'h0);
        tick(); drv(0, 0, 1, 1, 32'h8008, 8'hFF, 64'hBAD0_BAD0_BAD0_BAD0); settle();
        chk("oor_wr_gnt", a_gnt, 2'b01); push(0, 1, 1, 64'h0);
        tick(); drv(0, 0, 1, 0, 32'h08, 8'hFF, 64'h0); settle();
        chk("after_oor_wr_gnt", a_gnt, 2'b01); push(0, 1, 0, D08);

        // Latency-2 instance: reset right after a read grant flushes it.
        tick(); drv(1, 0, 1, 1, 32'h40, 8'hFF, DX); settle();
        chk("l2_wr_gnt", b_gnt, 2'b01); push(2, 2, 0, 64'h0);
        repeat (3) begin tick(); end
        tick(); drv(1, 0, 1, 0, 32'h40, 8'hFF, 64'h0); settle();
        chk("l2_rd_gnt", b_gnt, 2'b01);
        tick(); settle();
        chk("l2_busy_before_rst", b_busy, 1'b1);
        rst2 = 1'b1;
        #1;
        chk("l2_rst_clear", {62'd0, b_busy, b_rv[0]}, 64'd0);
        tick(); tick();
        rst2 = 1'b0;
        repeat (4) begin tick(); end
        settle();
        chk("l2_idle_after_rst", {61'd0, b_busy, b_rv}, 64'd0);
        tick(); drv(1, 0, 1, 0, 32'h40, 8'hFF, 64'h0); settle();
        chk("l2_rd2_gnt", b_gnt, 2'b01); push(2, 2, 0, DX);

        for (int i = 0; i < 20 && pending() != 0; i++) tick();
        tick(); tick();
        nvec++;
        if (pending() != 0) begin
            nfail++;
            $display("FAIL drain: got %0d responses outstanding want 0", pending());
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
